// File: rtl/fx2_slave_fifo_responder.sv
// fx2_slave_fifo_responder
// Peripheral-side model of an EZ-USB FX2 slave FIFO on the IFCLK bus.
// OUT endpoint: filled by the host stream port and read by the FPGA master over FD.
// IN endpoint: written by the master over FD and committed to the host drain port
// either automatically every PKT_WORDS words or on PKTEND.
// IN-endpoint pointers carry one extra wrap bit, so occupancy is a plain subtraction;
// the low DEPTH_LOG2 bits address the storage arrays.
module fx2_slave_fifo_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PKT_WORDS  = 256
) (
  input  logic        i_ifclk,
  input  logic        i_reset_n,
  inout  wire  [15:0] io_fd,
  input  logic        i_sloe,
  input  logic        i_slrd,
  input  logic        i_slwr,
  input  logic [1:0]  i_fifoadr,
  input  logic        i_pktend,
  output logic        o_flagb,
  output logic        o_flagc,
  input  logic [15:0] i_host_wr_data,
  input  logic        i_host_wr_valid,
  output logic        o_host_wr_ready,
  output logic [15:0] o_host_rd_data,
  output logic        o_host_rd_last,
  output logic        o_host_rd_valid,
  input  logic        i_host_rd_ready,
  output logic [7:0]  o_zlp_count,
  output logic [3:0]  o_err_flags
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t LP_FULL = cnt_t'(DEPTH);
  localparam cnt_t LP_PKT  = cnt_t'(PKT_WORDS);
  localparam logic [1:0] ADR_OUT = 2'b10;
  localparam logic [1:0] ADR_IN  = 2'b00;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [15:0] r_out_mem [DEPTH];
  logic [15:0] r_in_mem [DEPTH];
  logic        r_in_last_mem [DEPTH];

  // OUT endpoint state
  cnt_t        r_out_wr;
  cnt_t        r_out_rd;
  logic [15:0] r_out_head;
  logic        r_flagc;

  // IN endpoint state: write, commit and read pointers
  cnt_t        r_in_wr;
  cnt_t        r_in_cm;
  cnt_t        r_in_rd;
  logic [15:0] r_in_head;
  logic        r_flagb;

  logic [7:0]  r_zlp_count;
  logic [3:0]  r_err_flags;

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic w_rd_strobe;
  logic w_wr_strobe;
  logic w_rd_sel;
  logic w_wr_sel;
  logic w_pkt_sel;

  assign w_rd_strobe = ~i_slrd;
  assign w_wr_strobe = ~i_slwr;
  assign w_rd_sel    = w_rd_strobe && (i_fifoadr == ADR_OUT);
  assign w_wr_sel    = w_wr_strobe && (i_fifoadr == ADR_IN);
  assign w_pkt_sel   = ~i_pktend && (i_fifoadr == ADR_IN);

  // ---------------------------------------------------------------------------
  // OUT endpoint datapath
  // ---------------------------------------------------------------------------
  cnt_t w_out_count;
  logic w_out_empty;
  logic w_out_full;
  logic w_out_push;
  logic w_out_pop;
  cnt_t w_out_wr_next;
  cnt_t w_out_rd_next;
  cnt_t w_out_count_next;
  ptr_t w_out_wr_addr;
  ptr_t w_out_rd_addr_next;
  logic w_out_bypass;
  logic w_fd_oe;

  assign w_out_count        = r_out_wr - r_out_rd;
  assign w_out_empty        = (w_out_count == '0);
  assign w_out_full         = (w_out_count == LP_FULL);
  assign w_out_push         = i_host_wr_valid && !w_out_full;
  assign w_out_pop          = w_rd_sel && !w_out_empty;
  assign w_out_wr_next      = r_out_wr + cnt_t'(w_out_push);
  assign w_out_rd_next      = r_out_rd + cnt_t'(w_out_pop);
  assign w_out_count_next   = w_out_wr_next - w_out_rd_next;
  assign w_out_wr_addr      = r_out_wr[DEPTH_LOG2-1:0];
  assign w_out_rd_addr_next = w_out_rd_next[DEPTH_LOG2-1:0];
  // A word landing exactly where the next head will be has not reached the array yet.
  assign w_out_bypass       = w_out_push && (w_out_wr_addr == w_out_rd_addr_next);

  // FD is only driven while the master enables it on the OUT endpoint and a word exists.
  assign w_fd_oe = ~i_sloe && (i_fifoadr == ADR_OUT) && !w_out_empty;
  assign io_fd   = w_fd_oe ? r_out_head : 16'bz;

  assign o_host_wr_ready = !w_out_full;
  assign o_flagc         = r_flagc;

  // Host-side load into the OUT endpoint array
  always_ff @(posedge i_ifclk) begin
    if (i_reset_n && w_out_push) begin
      r_out_mem[w_out_wr_addr] <= i_host_wr_data;
    end
  end

  // OUT endpoint pointers, registered head prefetch and FLAGC
  always_ff @(posedge i_ifclk) begin
    if (!i_reset_n) begin
      r_out_wr   <= '0;
      r_out_rd   <= '0;
      r_out_head <= '0;
      r_flagc    <= 1'b0;
    end else begin
      r_out_wr   <= w_out_wr_next;
      r_out_rd   <= w_out_rd_next;
      r_out_head <= w_out_bypass ? i_host_wr_data : r_out_mem[w_out_rd_addr_next];
      r_flagc    <= (w_out_count_next != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // IN endpoint datapath
  // ---------------------------------------------------------------------------
  cnt_t w_in_count;
  cnt_t w_in_committed;
  logic w_in_full;
  logic w_in_push;
  logic w_in_pop;
  cnt_t w_in_wr_next;
  cnt_t w_in_rd_next;
  cnt_t w_in_pend_after;
  logic w_auto_commit;
  logic w_commit;
  logic w_zlp;
  cnt_t w_in_cm_next;
  ptr_t w_in_wr_addr;
  ptr_t w_in_rd_addr;
  ptr_t w_in_rd_addr_next;
  logic w_in_bypass;
  logic w_last_we;
  ptr_t w_last_addr;
  logic w_last_val;

  assign w_in_count      = r_in_wr - r_in_rd;
  assign w_in_committed  = r_in_cm - r_in_rd;
  assign w_in_full       = (w_in_count == LP_FULL);
  assign w_in_push       = w_wr_sel && !w_in_full;
  assign w_in_pop        = (w_in_committed != '0) && i_host_rd_ready;
  assign w_in_wr_next    = r_in_wr + cnt_t'(w_in_push);
  assign w_in_rd_next    = r_in_rd + cnt_t'(w_in_pop);
  // Pending count after this edge's write, so a same-edge PKTEND includes the word.
  assign w_in_pend_after = w_in_wr_next - r_in_cm;
  assign w_auto_commit   = w_in_push && (w_in_pend_after == LP_PKT);
  assign w_commit        = w_auto_commit || (w_pkt_sel && (w_in_pend_after != '0));
  assign w_zlp           = w_pkt_sel && (w_in_pend_after == '0);
  assign w_in_cm_next    = w_commit ? w_in_wr_next : r_in_cm;

  assign w_in_wr_addr      = r_in_wr[DEPTH_LOG2-1:0];
  assign w_in_rd_addr      = r_in_rd[DEPTH_LOG2-1:0];
  assign w_in_rd_addr_next = w_in_rd_next[DEPTH_LOG2-1:0];
  assign w_in_bypass       = w_in_push && (w_in_wr_addr == w_in_rd_addr_next);

  // Each written entry gets its last bit; a PKTEND without a write marks the newest entry.
  assign w_last_we   = w_in_push || w_commit;
  assign w_last_addr = w_in_push ? w_in_wr_addr : (w_in_wr_addr - ptr_t'(1));
  assign w_last_val  = w_in_push ? w_commit : 1'b1;

  assign o_flagb         = r_flagb;
  assign o_host_rd_valid = (w_in_committed != '0);
  assign o_host_rd_data  = o_host_rd_valid ? r_in_head : 16'h0000;
  assign o_host_rd_last  = o_host_rd_valid ? r_in_last_mem[w_in_rd_addr] : 1'b0;

  // Master write from FD into the IN endpoint array
  always_ff @(posedge i_ifclk) begin
    if (i_reset_n && w_in_push) begin
      r_in_mem[w_in_wr_addr] <= io_fd;
    end
  end

  // Per-entry packet-boundary bits
  always_ff @(posedge i_ifclk) begin
    if (i_reset_n && w_last_we) begin
      r_in_last_mem[w_last_addr] <= w_last_val;
    end
  end

  // IN endpoint pointers, commit, registered head prefetch and FLAGB
  always_ff @(posedge i_ifclk) begin
    if (!i_reset_n) begin
      r_in_wr   <= '0;
      r_in_cm   <= '0;
      r_in_rd   <= '0;
      r_in_head <= '0;
      r_flagb   <= 1'b1;
    end else begin
      r_in_wr   <= w_in_wr_next;
      r_in_cm   <= w_in_cm_next;
      r_in_rd   <= w_in_rd_next;
      r_in_head <= w_in_bypass ? io_fd : r_in_mem[w_in_rd_addr_next];
      r_flagb   <= ((w_in_wr_next - w_in_rd_next) != LP_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic [3:0] w_err_set;

  assign w_err_set[0] = w_rd_sel && w_out_empty;
  assign w_err_set[1] = w_wr_sel && w_in_full;
  assign w_err_set[2] = (w_rd_strobe && (i_fifoadr != ADR_OUT)) ||
                        (w_wr_strobe && (i_fifoadr != ADR_IN));
  assign w_err_set[3] = ~i_sloe && (i_fifoadr != ADR_OUT);

  // Sticky protocol error flags and the wrapping zero-length-packet counter
  always_ff @(posedge i_ifclk) begin
    if (!i_reset_n) begin
      r_err_flags <= '0;
      r_zlp_count <= '0;
    end else begin
      r_err_flags <= r_err_flags | w_err_set;
      r_zlp_count <= r_zlp_count + 8'(w_zlp);
    end
  end

  assign o_err_flags = r_err_flags;
  assign o_zlp_count = r_zlp_count;

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Directed bench for fx2_slave_fifo_responder with default parameters
// (256-entry endpoints, 256-word auto-commit). FD carries pull-ups so an
// undriven bus reads 16'hFFFF; no stimulus word uses that value.
module tb_fx2_slave_fifo_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  wire  [15:0] fd;
  logic [15:0] fd_val;
  logic        fd_oe;
  logic        sloe;
  logic        slrd;
  logic        slwr;
  logic [1:0]  fifoadr;
  logic        pktend;
  logic        flagb;
  logic        flagc;
  logic [15:0] host_wr_data;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [15:0] host_rd_data;
  logic        host_rd_last;
  logic        host_rd_valid;
  logic        host_rd_ready;
  logic [7:0]  zlp_count;
  logic [3:0]  err_flags;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] FD_Z = 16'hFFFF;

  always #5 clk = ~clk;

  assign fd = fd_oe ? fd_val : 16'bz;

  for (genvar gi = 0; gi < 16; gi++) begin : g_pull
    pullup (fd[gi]);
  end

  fx2_slave_fifo_responder dut (
    .i_ifclk         (clk),
    .i_reset_n       (rst_n),
    .io_fd           (fd),
    .i_sloe          (sloe),
    .i_slrd          (slrd),
    .i_slwr          (slwr),
    .i_fifoadr       (fifoadr),
    .i_pktend        (pktend),
    .o_flagb         (flagb),
    .o_flagc         (flagc),
    .i_host_wr_data  (host_wr_data),
    .i_host_wr_valid (host_wr_valid),
    .o_host_wr_ready (host_wr_ready),
    .o_host_rd_data  (host_rd_data),
    .o_host_rd_last  (host_rd_last),
    .o_host_rd_valid (host_rd_valid),
    .i_host_rd_ready (host_rd_ready),
    .o_zlp_count     (zlp_count),
    .o_err_flags     (err_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sloe          = 1'b1;
    slrd          = 1'b1;
    slwr          = 1'b1;
    pktend        = 1'b1;
    fifoadr       = 2'b11;
    host_wr_valid = 1'b0;
    host_wr_data  = 16'h0000;
    host_rd_ready = 1'b0;
    fd_oe         = 1'b0;
    fd_val        = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic host_load(input logic [15:0] d);
    host_wr_data  = d;
    host_wr_valid = 1'b1;
    tick();
    host_wr_valid = 1'b0;
  endtask

  task automatic master_write(input logic [15:0] d, input logic with_pktend);
    fifoadr = 2'b00;
    fd_oe   = 1'b1;
    fd_val  = d;
    slwr    = 1'b0;
    pktend  = ~with_pktend;
    tick();
    slwr    = 1'b1;
    pktend  = 1'b1;
    fd_oe   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++; if (flagb !== 1'b1) begin n_err++; $display("FAIL reset_flagb: got %b want 1", flagb); end
    n_vec++; if (flagc !== 1'b0) begin n_err++; $display("FAIL reset_flagc: got %b want 0", flagc); end
    n_vec++; if (fd !== FD_Z) begin n_err++; $display("FAIL reset_fd: got %h want Z", fd); end
    n_vec++; if (host_wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", host_wr_ready); end
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", host_rd_valid); end
    n_vec++; if (host_rd_last !== 1'b0) begin n_err++; $display("FAIL reset_rd_last: got %b want 0", host_rd_last); end
    n_vec++; if (host_rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", host_rd_data); end
    n_vec++; if (zlp_count !== 8'd0) begin n_err++; $display("FAIL reset_zlp: got %0d want 0", zlp_count); end
    n_vec++; if (err_flags !== 4'b0000) begin n_err++; $display("FAIL reset_err: got %b want 0000", err_flags); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_out_read();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      host_load(words[i]);
      if (i == 0) begin
        n_vec++; if (flagc !== 1'b1) begin n_err++; $display("FAIL out_flagc_rise: got %b want 1", flagc); end
      end
    end
    sloe    = 1'b0;
    fifoadr = 2'b10;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (fd !== words[i]) begin n_err++; $display("FAIL out_fd[%0d]: got %h want %h", i, fd, words[i]); end
      slrd = 1'b0;
      tick();
      slrd = 1'b1;
      if (i == 3) begin
        n_vec++; if (flagc !== 1'b0) begin n_err++; $display("FAIL out_flagc_fall: got %b want 0", flagc); end
      end
      tick();
    end
    n_vec++; if (fd !== FD_Z) begin n_err++; $display("FAIL out_fd_empty: got %h want Z", fd); end
    n_vec++; if (err_flags !== 4'b0000) begin n_err++; $display("FAIL out_err: got %b want 0000", err_flags); end
    sloe    = 1'b1;
    fifoadr = 2'b11;
  endtask

  task automatic test_back_to_back();
    host_load(16'h5555);
    sloe    = 1'b0;
    fifoadr = 2'b10;
    #1;
    n_vec++; if (fd !== 16'h5555) begin n_err++; $display("FAIL b2b_head: got %h want 5555", fd); end
    slrd          = 1'b0;
    host_wr_data  = 16'h6666;
    host_wr_valid = 1'b1;
    tick();
    host_wr_valid = 1'b0;
    n_vec++; if (flagc !== 1'b1) begin n_err++; $display("FAIL b2b_flagc: got %b want 1", flagc); end
    n_vec++; if (fd !== 16'h6666) begin n_err++; $display("FAIL b2b_new_head: got %h want 6666", fd); end
    tick();
    slrd = 1'b1;
    n_vec++; if (flagc !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", flagc); end
    n_vec++; if (fd !== FD_Z) begin n_err++; $display("FAIL b2b_fd_z: got %h want Z", fd); end
    sloe    = 1'b1;
    fifoadr = 2'b11;
  endtask

  task automatic test_auto_commit();
    for (int i = 0; i < 256; i++) begin
      master_write(16'(i), 1'b0);
      if (i == 254) begin
        n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL auto_early_valid: got %b want 0", host_rd_valid); end
      end
    end
    n_vec++; if (host_rd_valid !== 1'b1) begin n_err++; $display("FAIL auto_valid: got %b want 1", host_rd_valid); end
    n_vec++; if (flagb !== 1'b0) begin n_err++; $display("FAIL auto_flagb: got %b want 0", flagb); end
    host_rd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n_vec++; if (host_rd_valid !== 1'b1 || host_rd_data !== 16'(i) || host_rd_last !== (i == 255))
        begin n_err++; $display("FAIL auto_drain[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, host_rd_valid, host_rd_data, host_rd_last, 16'(i), (i == 255)); end
      tick();
    end
    host_rd_ready = 1'b0;
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL auto_empty: got %b want 0", host_rd_valid); end
    n_vec++; if (flagb !== 1'b1) begin n_err++; $display("FAIL auto_flagb_back: got %b want 1", flagb); end
    n_vec++; if (err_flags !== 4'b0000) begin n_err++; $display("FAIL auto_err: got %b want 0000", err_flags); end
  endtask

  task automatic test_pktend();
    logic [15:0] words [3];
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
    for (int i = 0; i < 3; i++) master_write(words[i], 1'b0);
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL pkt_uncommitted: got %b want 0", host_rd_valid); end
    fifoadr = 2'b00;
    pktend  = 1'b0;
    tick();
    n_vec++; if (host_rd_valid !== 1'b1) begin n_err++; $display("FAIL pkt_valid: got %b want 1", host_rd_valid); end
    n_vec++; if (zlp_count !== 8'd0) begin n_err++; $display("FAIL pkt_zlp0: got %0d want 0", zlp_count); end
    tick();
    pktend = 1'b1;
    n_vec++; if (zlp_count !== 8'd1) begin n_err++; $display("FAIL pkt_zlp1: got %0d want 1", zlp_count); end
    host_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (host_rd_valid !== 1'b1 || host_rd_data !== words[i] || host_rd_last !== (i == 2))
        begin n_err++; $display("FAIL pkt_drain[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, host_rd_valid, host_rd_data, host_rd_last, words[i], (i == 2)); end
      tick();
    end
    host_rd_ready = 1'b0;
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL pkt_no_extra: got %b want 0", host_rd_valid); end
  endtask

  task automatic test_pktend_with_write();
    logic [15:0] words [3];
    words[0] = 16'hB001; words[1] = 16'hB002; words[2] = 16'hB003;
    master_write(words[0], 1'b0);
    master_write(words[1], 1'b0);
    master_write(words[2], 1'b1);
    n_vec++; if (host_rd_valid !== 1'b1) begin n_err++; $display("FAIL pkw_valid: got %b want 1", host_rd_valid); end
    n_vec++; if (zlp_count !== 8'd1) begin n_err++; $display("FAIL pkw_zlp: got %0d want 1", zlp_count); end
    host_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (host_rd_valid !== 1'b1 || host_rd_data !== words[i] || host_rd_last !== (i == 2))
        begin n_err++; $display("FAIL pkw_drain[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, host_rd_valid, host_rd_data, host_rd_last, words[i], (i == 2)); end
      tick();
    end
    host_rd_ready = 1'b0;
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL pkw_empty: got %b want 0", host_rd_valid); end
  endtask

  task automatic test_errors();
    do_reset();
    fifoadr = 2'b10;
    slrd    = 1'b0;
    tick();
    slrd    = 1'b1;
    n_vec++; if (err_flags !== 4'b0001) begin n_err++; $display("FAIL err_rd_empty: got %b want 0001", err_flags); end
    slwr    = 1'b0;
    tick();
    slwr    = 1'b1;
    n_vec++; if (err_flags !== 4'b0101) begin n_err++; $display("FAIL err_wr_badadr: got %b want 0101", err_flags); end
    fifoadr = 2'b00;
    sloe    = 1'b0;
    tick();
    n_vec++; if (err_flags !== 4'b1101) begin n_err++; $display("FAIL err_sloe_badadr: got %b want 1101", err_flags); end
    n_vec++; if (fd !== FD_Z) begin n_err++; $display("FAIL err_fd_z: got %h want Z", fd); end
    sloe    = 1'b1;
    fifoadr = 2'b11;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      master_write(16'h8000 + 16'(i), 1'b0);
      if (i == 254) begin
        n_vec++; if (flagb !== 1'b1) begin n_err++; $display("FAIL fill_flagb_255: got %b want 1", flagb); end
      end
      if (i == 255) begin
        n_vec++; if (flagb !== 1'b0) begin n_err++; $display("FAIL fill_flagb_256: got %b want 0", flagb); end
      end
    end
    master_write(16'hDEAD, 1'b0);
    n_vec++; if (err_flags !== 4'b0010) begin n_err++; $display("FAIL fill_err: got %b want 0010", err_flags); end
    n_vec++; if (flagb !== 1'b0) begin n_err++; $display("FAIL fill_flagb_hold: got %b want 0", flagb); end
    host_rd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n_vec++; if (host_rd_valid !== 1'b1 || host_rd_data !== (16'h8000 + 16'(i)) || host_rd_last !== (i == 255))
        begin n_err++; $display("FAIL fill_drain[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, host_rd_valid, host_rd_data, host_rd_last, 16'h8000 + 16'(i), (i == 255)); end
      tick();
    end
    host_rd_ready = 1'b0;
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", host_rd_valid); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    host_load(16'h7777);
    host_load(16'h7778);
    for (int i = 0; i < 5; i++) master_write(16'hC000 + 16'(i), 1'b0);
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_pre_valid: got %b want 0", host_rd_valid); end
    n_vec++; if (flagc !== 1'b1) begin n_err++; $display("FAIL mid_pre_flagc: got %b want 1", flagc); end
    // Reset edge coincides with a write, a PKTEND and a host load
    rst_n         = 1'b0;
    fifoadr       = 2'b00;
    fd_oe         = 1'b1;
    fd_val        = 16'h1234;
    slwr          = 1'b0;
    pktend        = 1'b0;
    host_wr_data  = 16'h9999;
    host_wr_valid = 1'b1;
    tick();
    idle();
    sloe    = 1'b0;
    fifoadr = 2'b10;
    #1;
    n_vec++; if (flagb !== 1'b1) begin n_err++; $display("FAIL mid_flagb: got %b want 1", flagb); end
    n_vec++; if (flagc !== 1'b0) begin n_err++; $display("FAIL mid_flagc: got %b want 0", flagc); end
    n_vec++; if (fd !== FD_Z) begin n_err++; $display("FAIL mid_fd: got %h want Z", fd); end
    n_vec++; if (host_wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_wr_ready: got %b want 1", host_wr_ready); end
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rd_valid: got %b want 0", host_rd_valid); end
    n_vec++; if (host_rd_last !== 1'b0) begin n_err++; $display("FAIL mid_rd_last: got %b want 0", host_rd_last); end
    n_vec++; if (host_rd_data !== 16'h0000) begin n_err++; $display("FAIL mid_rd_data: got %h want 0000", host_rd_data); end
    n_vec++; if (zlp_count !== 8'd0) begin n_err++; $display("FAIL mid_zlp: got %0d want 0", zlp_count); end
    n_vec++; if (err_flags !== 4'b0000) begin n_err++; $display("FAIL mid_err: got %b want 0000", err_flags); end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_valid[%0d]: got %b want 0", i, host_rd_valid); end
    end
    // Discarded words must not be committed by a later PKTEND
    fifoadr = 2'b00;
    pktend  = 1'b0;
    tick();
    pktend  = 1'b1;
    n_vec++; if (zlp_count !== 8'd1) begin n_err++; $display("FAIL mid_post_zlp: got %0d want 1", zlp_count); end
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_commit: got %b want 0", host_rd_valid); end
    n_vec++; if (flagc !== 1'b0) begin n_err++; $display("FAIL mid_post_flagc: got %b want 0", flagc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_out_read();
    test_back_to_back();
    test_auto_commit();
    test_pktend();
    test_pktend_with_write();
    test_errors();
    test_fill_overflow();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
